// File: rtl/spi_miso_deframer.sv
// spi_miso_deframer: splits 64-bit two-lane MISO FIFO words into bytes and assembles AstroPix hit frames.
// Optional header check (byte[7:5]==3'b001) and bad_header_count port under SPI_DEFRAMER_HEADER_CHECK_EN.
module spi_miso_deframer #(
    parameter int         FRAME_BYTES = 5,
    parameter logic [7:0] IDLE_BYTE   = 8'hBC
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [1:0]               lane_enable,
    input  logic [63:0]              fifo_data,
    input  logic                     fifo_empty,
    output logic                     fifo_rd_en,
    output logic [8*FRAME_BYTES-1:0] frame_data,
    output logic                     frame_valid,
    input  logic                     frame_ready,
    output logic [15:0]              frame_count,
    output logic [15:0]              idle_count
`ifdef SPI_DEFRAMER_HEADER_CHECK_EN
    ,
    output logic [15:0]              bad_header_count
`endif
);
    typedef enum logic [1:0] {FETCH, LATCH, EMIT} word_state_t;
    typedef enum logic {HUNT, COLLECT} parse_state_t;

    word_state_t              state, state_next;
    parse_state_t             parse;
    logic [63:0]              word;
    logic                     lane1_on;
    logic [2:0]               idx;
    logic [31:0]              lane0, lane1, lane;
    logic [7:0]               data_byte;
    logic                     byte_valid, stall, last, header_ok, complete;
    logic [3:0]               count;
    logic [8*FRAME_BYTES-9:0] acc;
    logic [8*FRAME_BYTES-1:0] shifted;

    always_comb begin
        for (int k = 0; k < 32; k++) begin
            lane0[k] = word[2*k+1];
            lane1[k] = word[2*k];
        end
        lane = idx[2] ? lane1 : lane0;
        data_byte = lane[5'd31 - {idx[1:0], 3'b000} -: 8];
        stall = frame_valid & ~frame_ready;
        last = (idx == 3'd7) | ((idx == 3'd3) & ~lane1_on);
        state_next = state;
        fifo_rd_en = 1'b0;
        byte_valid = 1'b0;
        case (state)
            FETCH: begin
                fifo_rd_en = enable & ~fifo_empty & ~stall & ~reset;
                state_next = fifo_rd_en ? LATCH : FETCH;
            end
            LATCH: state_next = (lane_enable == 2'b00) ? FETCH : EMIT;
            EMIT: begin
                byte_valid = ~stall;
                state_next = (~stall & last) ? FETCH : EMIT;
            end
            default: state_next = FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
            idx <= 3'd0;
            word <= 64'd0;
            lane1_on <= 1'b0;
        end else begin
            state <= state_next;
            if (state == LATCH) begin
                word <= fifo_data;
                lane1_on <= lane_enable[1];
                idx <= lane_enable[0] ? 3'd0 : 3'd4;
            end else if (byte_valid) begin
                idx <= (idx == 3'd3) ? 3'd4 : idx + 3'd1;
            end
        end
    end

`ifdef SPI_DEFRAMER_HEADER_CHECK_EN
    assign header_ok = (data_byte[7:5] == 3'b001);
`else
    assign header_ok = 1'b1;
`endif
    assign shifted = {acc, data_byte};
    assign complete = byte_valid & ~clear & (parse == COLLECT) & (count == 4'(FRAME_BYTES - 1));

    // a frame completing in the same cycle it is accepted replaces it without a valid gap
    always_ff @(posedge clock) begin
        if (reset) begin
            parse <= HUNT;
            count <= 4'd0;
            acc <= '0;
            frame_data <= '0;
            frame_valid <= 1'b0;
            frame_count <= 16'd0;
            idle_count <= 16'd0;
`ifdef SPI_DEFRAMER_HEADER_CHECK_EN
            bad_header_count <= 16'd0;
`endif
        end else begin
            if (complete) begin
                frame_data <= shifted;
                frame_valid <= 1'b1;
                frame_count <= frame_count + 16'd1;
            end else if (frame_ready) begin
                frame_valid <= 1'b0;
            end
            if (clear) begin
                parse <= HUNT;
                count <= 4'd0;
            end else if (byte_valid) begin
                if (parse == COLLECT) begin
                    acc <= shifted[8*FRAME_BYTES-9:0];
                    count <= complete ? 4'd0 : count + 4'd1;
                    parse <= complete ? HUNT : COLLECT;
                end else if (data_byte == IDLE_BYTE) begin
                    idle_count <= idle_count + {15'd0, ~&idle_count};
                end else if (header_ok) begin
                    acc <= shifted[8*FRAME_BYTES-9:0];
                    count <= 4'd1;
                    parse <= COLLECT;
                end
`ifdef SPI_DEFRAMER_HEADER_CHECK_EN
                else begin
                    bad_header_count <= bad_header_count + {15'd0, ~&bad_header_count};
                end
`endif
            end
        end
    end
endmodule

// File: tb/tb_spi_miso_deframer.sv
// tb_spi_miso_deframer: scoreboard bench; a byte-level reference model queues expected frames as words are pushed.
module tb_spi_miso_deframer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  lane_enable = 2'b11;
    logic [63:0] fifo_data = 64'd0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [39:0] frame_data;
    logic        frame_valid;
    logic        frame_ready = 1'b1;
    logic [15:0] frame_count;
    logic [15:0] idle_count;

    int n_checks = 0;
    int n_fails = 0;
    int rd_pulses = 0;
    int valid_cycles = 0;
    int m_idle = 0;
    int m_frames = 0;
    int m_cnt = 0;
    bit m_collect = 0;
    logic [39:0] m_frame = 40'd0;
    logic [63:0] fifo_q[$];
    logic [39:0] exp_q[$];

    spi_miso_deframer dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .clear(clear),
        .lane_enable(lane_enable),
        .fifo_data(fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_rd_en(fifo_rd_en),
        .frame_data(frame_data),
        .frame_valid(frame_valid),
        .frame_ready(frame_ready),
        .frame_count(frame_count),
        .idle_count(idle_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (fifo_rd_en && fifo_q.size() > 0) fifo_data <= fifo_q.pop_front();
        fifo_empty <= (fifo_q.size() == 0);
    end

    always @(negedge clock) begin
        logic [39:0] e;
        if (frame_valid) valid_cycles++;
        if (fifo_rd_en) rd_pulses++;
        if (frame_valid && frame_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL frame_unexpected: got %h, none queued", frame_data);
            end else begin
                e = exp_q.pop_front();
                if (frame_data !== e) begin
                    n_fails++;
                    $display("FAIL frame_data: got %h expected %h", frame_data, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_collect) begin
            if (b == 8'hBC) m_idle++;
            else begin
                m_frame = {32'd0, b};
                m_cnt = 1;
                m_collect = 1;
            end
        end else begin
            m_frame = {m_frame[31:0], b};
            m_cnt++;
            if (m_cnt == 5) begin
                exp_q.push_back(m_frame);
                m_frames++;
                m_collect = 0;
            end
        end
    endtask

    task automatic model_reset;
        m_collect = 0;
        m_cnt = 0;
        m_idle = 0;
        m_frames = 0;
        exp_q.delete();
    endtask

    task automatic push_word(input logic [31:0] l0, input logic [31:0] l1);
        logic [63:0] w;
        for (int k = 0; k < 32; k++) begin
            w[2*k+1] = l0[k];
            w[2*k] = l1[k];
        end
        fifo_q.push_back(w);
        if (lane_enable[0]) for (int n = 0; n < 4; n++) model_byte(l0[31-8*n -: 8]);
        if (lane_enable[1]) for (int n = 0; n < 4; n++) model_byte(l1[31-8*n -: 8]);
    endtask

    task automatic drain;
        for (int i = 0; i < 300 && fifo_q.size() != 0; i++) tick();
        repeat (15) tick();
        n_checks++;
        if (fifo_q.size() != 0 || exp_q.size() != 0) begin
            n_fails++;
            $display("FAIL drain: fifo words=%0d frames outstanding=%0d, expected 0 and 0", fifo_q.size(), exp_q.size());
        end
    endtask

    task automatic check_counts(input string name);
        n_checks++;
        if (frame_count !== 16'(m_frames) || idle_count !== 16'(m_idle)) begin
            n_fails++;
            $display("FAIL %s counts: frame_count=%0d idle_count=%0d expected %0d %0d", name, frame_count, idle_count, m_frames, m_idle);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick();
        n_checks++;
        if (fifo_rd_en !== 1'b0 || frame_valid !== 1'b0 || frame_data !== 40'd0 || frame_count !== 16'd0 || idle_count !== 16'd0) begin
            n_fails++;
            $display("FAIL reset: rd=%b valid=%b data=%h fc=%0d ic=%0d expected all zero", fifo_rd_en, frame_valid, frame_data, frame_count, idle_count);
        end
        reset = 1'b0;
        enable = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int p0, v0;
        lane_enable = 2'b11;
        frame_ready = 1'b1;
        p0 = rd_pulses;
        v0 = valid_cycles;
        push_word(32'h20123456, 32'h78BCBCBC);
        drain();
        n_checks++;
        if (frame_count !== 16'd1 || idle_count !== 16'd3) begin
            n_fails++;
            $display("FAIL basic counts: frame_count=%0d idle_count=%0d expected 1 3", frame_count, idle_count);
        end
        n_checks++;
        if (valid_cycles - v0 != 1 || rd_pulses - p0 != 1) begin
            n_fails++;
            $display("FAIL basic timing: valid cycles=%0d reads=%0d expected 1 1", valid_cycles - v0, rd_pulses - p0);
        end
    endtask

    task automatic test_all_idle;
        int p0, i0, f0;
        p0 = rd_pulses;
        i0 = idle_count;
        f0 = frame_count;
        enable = 1'b0;
        push_word(32'hBCBCBCBC, 32'hBCBCBCBC);
        repeat (10) tick();
        n_checks++;
        if (rd_pulses != p0) begin
            n_fails++;
            $display("FAIL enable_low: reads=%0d expected 0", rd_pulses - p0);
        end
        enable = 1'b1;
        drain();
        n_checks++;
        if (int'(idle_count) - i0 != 8 || int'(frame_count) != f0 || rd_pulses - p0 != 1) begin
            n_fails++;
            $display("FAIL all_idle: idle delta=%0d frames delta=%0d reads=%0d expected 8 0 1", int'(idle_count) - i0, int'(frame_count) - f0, rd_pulses - p0);
        end
        check_counts("all_idle");
    endtask

    task automatic test_lane0_span;
        int i0;
        i0 = idle_count;
        lane_enable = 2'b01;
        push_word(32'hBC21AABB, 32'hFFFFFFFF);
        push_word(32'hCCDDBCBC, 32'h20202020);
        drain();
        n_checks++;
        if (int'(idle_count) - i0 != 3) begin
            n_fails++;
            $display("FAIL lane0_span idle: delta=%0d expected 3", int'(idle_count) - i0);
        end
        check_counts("lane0_span");
    endtask

    task automatic test_backpressure;
        int p0, bad, i;
        lane_enable = 2'b11;
        frame_ready = 1'b0;
        push_word(32'h20010203, 32'h04BCBCBC);
        for (i = 0; i < 100 && !frame_valid; i++) tick();
        n_checks++;
        if (!frame_valid) begin
            n_fails++;
            $display("FAIL backpressure wait: frame_valid=%b expected 1 within 100 cycles", frame_valid);
        end
        push_word(32'h21111213, 32'h14BCBCBC);
        push_word(32'h22212223, 32'h24BCBCBC);
        p0 = rd_pulses;
        bad = 0;
        repeat (20) begin
            tick();
            if (frame_valid !== 1'b1 || frame_data !== 40'h2001020304) bad++;
        end
        n_checks++;
        if (bad != 0 || rd_pulses != p0) begin
            n_fails++;
            $display("FAIL backpressure hold: unstable cycles=%0d reads=%0d expected 0 0", bad, rd_pulses - p0);
        end
        frame_ready = 1'b1;
        drain();
        check_counts("backpressure");
    endtask

    task automatic test_clear;
        int f0;
        f0 = frame_count;
        lane_enable = 2'b01;
        push_word(32'hBC2A1112, 32'h00000000);
        drain();
        clear = 1'b1;
        m_collect = 0;
        tick();
        clear = 1'b0;
        push_word(32'h21334455, 32'h00000000);
        push_word(32'h66BCBCBC, 32'h00000000);
        drain();
        n_checks++;
        if (int'(frame_count) - f0 != 1) begin
            n_fails++;
            $display("FAIL clear frames: delta=%0d expected 1", int'(frame_count) - f0);
        end
        check_counts("clear");
    endtask

    task automatic test_reset_mid;
        int i;
        lane_enable = 2'b11;
        push_word(32'h20AABBCC, 32'hDDBCBCBC);
        for (i = 0; i < 50 && !fifo_rd_en; i++) tick();
        repeat (3) tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if (fifo_rd_en !== 1'b0 || frame_valid !== 1'b0 || frame_data !== 40'd0 || frame_count !== 16'd0 || idle_count !== 16'd0) begin
            n_fails++;
            $display("FAIL reset_mid: rd=%b valid=%b data=%h fc=%0d ic=%0d expected all zero", fifo_rd_en, frame_valid, frame_data, frame_count, idle_count);
        end
        reset = 1'b0;
        model_reset();
        fifo_q.delete();
        tick();
        push_word(32'h23A1A2A3, 32'hA4BCBCBC);
        drain();
        n_checks++;
        if (frame_count !== 16'd1 || idle_count !== 16'd3) begin
            n_fails++;
            $display("FAIL reset_mid restart: frame_count=%0d idle_count=%0d expected 1 3", frame_count, idle_count);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_all_idle();
        test_lane0_span();
        test_backpressure();
        test_clear();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/spi_miso_deframer.md
Name: spi_miso_deframer

Overview:
- Downstream consumer of the 5-wire SPI readout block's 64-bit MISO read FIFO, on the system `clock` side of the async FIFO.
- Each FIFO word is 32 SPI clocks of two interleaved MISO lanes. The block splits the word into per-lane byte streams and strips idle filler bytes.
- It assembles fixed-length AstroPix hit frames and presents them on a valid/ready interface toward the FTDI readout path.

Parameters:
- FRAME_BYTES, 5, bytes per hit frame including the header byte (legal range 2..8).
- IDLE_BYTE, 8'hBC, filler byte the chip shifts out when it has no data; dropped while hunting for a header.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  when 0, no new FIFO reads; the word in progress finishes.
- clear  input  1  one-cycle pulse: parser returns to HUNT and the partial frame is discarded; FIFO and output are untouched.
- lane_enable  input  2  bit0 = MISO0 lane emitted, bit1 = MISO1 lane emitted.
- fifo_data  input  64  read data of the MISO FIFO.
- fifo_empty  input  1  MISO FIFO empty.
- fifo_rd_en  output  1  MISO FIFO read strobe; data is valid on the cycle after the strobe.
- frame_data  output  8*FRAME_BYTES  assembled frame; header in the most significant byte.
- frame_valid  output  1  frame available.
- frame_ready  input  1  consumer accepts the frame when valid and ready are both high.
- frame_count  output  16  frames emitted, wraps at 0xFFFF to 0.
- idle_count  output  16  idle bytes dropped in HUNT, saturates at 0xFFFF.

Behaviour:
- Reset values: fifo_rd_en=0, frame_valid=0, frame_data=0, frame_count=0, idle_count=0. Word FSM goes to FETCH, parser to HUNT, byte index to 0.
- Stall condition: stall = frame_valid & ~frame_ready. While stall is high, the byte stage and FIFO reads freeze.
- Lane extraction: lane0 bit k = word bit 2k+1; lane1 bit k = word bit 2k, for k=0..31. Byte n of a lane = lane[31-8n -: 8], so byte 0 is the oldest.
- Byte order per word: lane0 bytes 0..3, then lane1 bytes 0..3. Bytes of a disabled lane are skipped with zero cycles spent on them.
- Word FSM states:
  - FETCH: if enable & ~fifo_empty & ~stall, pulse fifo_rd_en for one cycle and go to LATCH.
  - LATCH: register fifo_data into the word buffer. Go to EMIT at the first enabled byte index; if lane_enable=0, go straight back to FETCH (word discarded).
  - EMIT: when not stalled, deliver one byte per cycle to the parser. After the last enabled byte, go to FETCH.
  - Throughput: 1 FIFO read every (enabled bytes + 2) cycles when unstalled.
- lane_enable is sampled in LATCH and held for the rest of that word.
- Parser HUNT:
  - byte == IDLE_BYTE: drop it and increment idle_count (saturating).
  - Otherwise: store it as frame byte 0, set count=1, go to COLLECT.
- Parser COLLECT:
  - Every byte is stored, including IDLE_BYTE values, since payload may legitimately contain 0xBC.
  - When count reaches FRAME_BYTES: load frame_data, set frame_valid=1 on the next edge, increment frame_count, return to HUNT.
- Frames span word boundaries freely.
- Output: frame_valid stays high and frame_data stays stable until accepted.
  - Accept with no new frame completing: frame_valid drops on the next cycle.
  - Accept in the same cycle a new frame completes: the new frame loads and frame_valid stays 1.
- clear:
  - In COLLECT: the partial frame is dropped.
  - In the same cycle as a completing byte: clear wins and no frame is emitted.
  - Never cancels a pending frame_valid.
- fifo_empty asserted mid-word has no effect; the buffered word is fully emitted.
- Reset mid-frame discards the word buffer and the partial frame.

Optional Feature:
- Macro: SPI_DEFRAMER_HEADER_CHECK_EN.
- With it: in HUNT, a byte is accepted as a header only if byte[7:5]==3'b001. A non-idle byte failing the check is dropped and increments an extra output bad_header_count [15:0] (saturating, reset 0).
- Without it: any non-IDLE_BYTE byte starts a frame and the bad_header_count port does not exist.

Test Plan:
- Word lane0=0x20123456, lane1=0x78BCBCBC, lane_enable=2'b11, frame_ready=1 -> frame_data=0x2012345678 one cycle valid; frame_count=1; idle_count=3.
- Word lane0=0xBCBCBCBC, lane1=0xBCBCBCBC -> no frame; idle_count=8; exactly one fifo_rd_en pulse.
- lane_enable=2'b01, two words lane0=0xBC21AABB, lane0=0xCCDDBCBC -> frame 0x21AABBCCDD spans words; idle_count=3; lane1 bytes never reach parser.
- frame_ready held 0 with a frame pending and 2 more words in FIFO -> fifo_rd_en stays 0, frame_data stable. Raise ready -> second frame follows, no byte lost.
- clear pulsed after 3 bytes of a frame -> partial discarded; the next 5 non-idle bytes form a frame; frame_count increments once.
- Reset asserted during EMIT -> all outputs zero next cycle; after release, the first word is parsed from HUNT.
